dut: RTL and testbench

- Single-cycle, 8-bit, accumulator-style processor for the CSE141L project. Instruction and data memories are internal.
- Runs the team's multiply program: reads signed operands from dm[0] and dm[1], writes the signed 16-bit product to dm[3] (high byte) and dm[2] (low byte), then raises done.
- Top level of the design. The testbench loads the memories hierarchically.

---
 rtl/dut_pkg.sv | 32 +++
 rtl/dut_alu.sv | 59 +++++
 rtl/dut_mem.sv | 43 ++++
 rtl/dut.sv | 147 ++++++++++++++
 tb/tb_dut.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/dut_pkg.sv
// dut_pkg: shared types and constants for the 8-bit accumulator core.
// Opcode 12 is MUL only in builds that define MUL_INSTR_EN.
package dut_pkg;

  localparam int INSTR_W = 9;
  localparam int DATA_W  = 8;

  typedef enum logic [3:0] {
    OP_LDI  = 4'd0,
    OP_PUT  = 4'd1,
    OP_GET  = 4'd2,
    OP_LDM  = 4'd3,
    OP_STM  = 4'd4,
    OP_ADD  = 4'd5,
    OP_ADC  = 4'd6,
    OP_SUB  = 4'd7,
    OP_AND  = 4'd8,
    OP_XOR  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_MUL  = 4'd12,
    OP_BZ   = 4'd13,
    OP_BNZ  = 4'd14,
    OP_HALT = 4'd15
  } opcode_e;

  typedef struct packed {
    opcode_e    op;
    logic [4:0] n;
  } instr_t;

endpackage

// File: rtl/dut_alu.sv
// alu: combinational datapath producing the next r0, carry and zero.
// With MUL_INSTR_EN, opcode 12 yields a signed 16-bit product on o_hi:o_res.
module alu
  import dut_pkg::*;
(
  input  opcode_e           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_c,
  output logic [DATA_W-1:0] o_res,
  output logic [DATA_W-1:0] o_hi,
  output logic              o_c,
  output logic              o_z
);
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_dif;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_cin;

  assign w_cin = i_c & (i_op == OP_ADC);
  assign w_sum = {1'b0, i_a} + {1'b0, i_b}
               + {{DATA_W{1'b0}}, w_cin};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

`ifdef MUL_INSTR_EN
  assign w_prod = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a})
                * $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
`else
  assign w_prod = '0;
`endif

  always_comb begin
    o_res = i_a;
    o_hi  = '0;
    o_c   = i_c;
    unique case (i_op)
      OP_LDI, OP_GET, OP_LDM: o_res = i_b;
      OP_ADD, OP_ADC: {o_c, o_res} = w_sum;
      // Carry on subtract means "no borrow".
      OP_SUB: begin
        o_res = w_dif[DATA_W-1:0];
        o_c   = ~w_dif[DATA_W];
      end
      OP_AND: o_res = i_a & i_b;
      OP_XOR: o_res = i_a ^ i_b;
      OP_SHL: begin
        o_c   = i_a[DATA_W-1];
        o_res = {i_a[DATA_W-2:0], 1'b0};
      end
      OP_SHR: begin
        o_c   = i_a[0];
        o_res = {1'b0, i_a[DATA_W-1:1]};
      end
      OP_MUL: {o_hi, o_res} = w_prod;
      default: ;
    endcase
    o_z = ({o_hi, o_res} == '0);
  end
endmodule

// File: rtl/dut_mem.sv
// dut_mem: instruction store (im) and byte data store (dm).
// Both read combinationally; neither is cleared by reset.
module instr_mem
  import dut_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [PC_W-1:0]    i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [PC_W-1:0]    i_addr,
  output logic [INSTR_W-1:0] o_data
);
  logic [INSTR_W-1:0] instr_core [2**PC_W];

  // Loader port; the core itself never writes program memory.
  always_ff @(posedge clk) begin
    if (i_we) instr_core[i_waddr] <= i_wdata;
  end

  assign o_data = instr_core[i_addr];
endmodule

module data_mem
  import dut_pkg::*;
#(
  parameter int DM_AW = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [DM_AW-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] core [2**DM_AW];

  always_ff @(posedge clk) begin
    if (i_we) core[i_addr] <= i_wdata;
  end

  assign o_rdata = core[i_addr];
endmodule

// File: rtl/dut.sv
// dut: single-cycle 8-bit accumulator core with internal im/dm memories.
// Define MUL_INSTR_EN to make opcode 12 a signed multiply into r1:r0.
module dut
  import dut_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int DM_AW = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_rf [8];
  logic              r_z;
  logic              r_c;
  logic              r_done;

  logic [INSTR_W-1:0] w_im_rdata;
  instr_t             w_ins;
  logic [4:0]         w_n;
  logic [DATA_W-1:0]  w_r0;
  logic [DATA_W-1:0]  w_rn;
  logic [DATA_W-1:0]  w_b;
  logic [DATA_W-1:0]  w_dm_rdata;
  logic [DATA_W-1:0]  w_res;
  logic [DATA_W-1:0]  w_res_hi;
  logic               w_c;
  logic               w_z;
  logic               w_run;
  logic               w_wr_r0;
  logic               w_wr_r1;
  logic               w_wr_rn;
  logic               w_wr_c;
  logic               w_dm_we;
  logic               w_halt;
  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_pc_br;
  logic [PC_W-1:0]    w_pc_next;

  assign w_ins  = instr_t'(w_im_rdata);
  assign w_n    = w_ins.n;
  assign w_r0   = r_rf[0];
  assign w_rn   = r_rf[w_n[2:0]];
  assign w_run  = ~start & ~r_done;
  assign done   = r_done;

  assign w_pc_inc = r_pc + 1'b1;
  assign w_pc_br  = r_pc + PC_W'($signed(w_n));

  instr_mem #(.PC_W(PC_W)) im (
    .clk     (clk),
    .i_we    (1'b0),
    .i_waddr ({PC_W{1'b0}}),
    .i_wdata ({INSTR_W{1'b0}}),
    .i_addr  (r_pc),
    .o_data  (w_im_rdata)
  );

  data_mem #(.DM_AW(DM_AW)) dm (
    .clk     (clk),
    .i_we    (w_dm_we & w_run),
    .i_addr  (DM_AW'(w_rn)),
    .i_wdata (w_r0),
    .o_rdata (w_dm_rdata)
  );

  alu u_alu (
    .i_op  (w_ins.op),
    .i_a   (w_r0),
    .i_b   (w_b),
    .i_c   (r_c),
    .o_res (w_res),
    .o_hi  (w_res_hi),
    .o_c   (w_c),
    .o_z   (w_z)
  );

  always_comb begin
    w_b       = w_rn;
    w_wr_r0   = 1'b0;
    w_wr_r1   = 1'b0;
    w_wr_rn   = 1'b0;
    w_wr_c    = 1'b0;
    w_dm_we   = 1'b0;
    w_halt    = 1'b0;
    w_pc_next = w_pc_inc;
    unique case (w_ins.op)
      OP_LDI: begin
        w_b     = {{(DATA_W-5){1'b0}}, w_n};
        w_wr_r0 = 1'b1;
      end
      OP_PUT: w_wr_rn = 1'b1;
      OP_GET: w_wr_r0 = 1'b1;
      OP_LDM: begin
        w_b     = w_dm_rdata;
        w_wr_r0 = 1'b1;
      end
      OP_STM: w_dm_we = 1'b1;
      OP_ADD, OP_ADC, OP_SUB, OP_SHL, OP_SHR: begin
        w_wr_r0 = 1'b1;
        w_wr_c  = 1'b1;
      end
      OP_AND, OP_XOR: w_wr_r0 = 1'b1;
`ifdef MUL_INSTR_EN
      OP_MUL: begin
        w_wr_r0 = 1'b1;
        w_wr_r1 = 1'b1;
      end
`else
      OP_MUL: ;
`endif
      OP_BZ:  if (r_z)  w_pc_next = w_pc_br;
      OP_BNZ: if (!r_z) w_pc_next = w_pc_br;
      OP_HALT: begin
        w_halt    = 1'b1;
        w_pc_next = r_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= '0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_done <= 1'b0;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (start) begin
      r_pc   <= '0;
      r_done <= 1'b0;
    end else if (!r_done) begin
      r_pc <= w_pc_next;
      if (w_halt) r_done <= 1'b1;
      if (w_wr_c) r_c <= w_c;
      // PUT copies r0 out; r1 takes the product high byte on MUL.
      if (w_wr_rn) r_rf[w_n[2:0]] <= w_r0;
      if (w_wr_r1) r_rf[1] <= w_res_hi;
      if (w_wr_r0) begin
        r_rf[0] <= w_res;
        r_z     <= w_z;
      end
    end
  end
endmodule

// File: tb/tb_dut.sv
// tb_dut: directed checks of the accumulator core running a signed multiply.
// The MUL_INSTR_EN build additionally checks opcode 12 as MUL.
module tb_dut;
  import dut_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b1;
  logic done;
  int   total = 0;
  int   bad = 0;
  int   pi = 0;

  dut #(.PC_W(8), .DM_AW(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic emit(input opcode_e op, input int n);
    u_dut.im.instr_core[pi] = {op, 5'(n)};
    pi++;
  endtask

  task automatic clear_im();
    for (int k = 0; k < 256; k++) u_dut.im.instr_core[k] = {OP_HALT, 5'd0};
    pi = 0;
  endtask

  // Shift-add of sext(a) by unsigned b, then high byte -= a when b < 0.
  task automatic load_mul();
    clear_im();
    emit(OP_LDI,1); emit(OP_PUT,1); emit(OP_LDI,0); emit(OP_PUT,7);
    emit(OP_LDM,7); emit(OP_PUT,2); emit(OP_SHL,0); emit(OP_LDI,0);
    emit(OP_ADC,0); emit(OP_PUT,7); emit(OP_LDI,0); emit(OP_SUB,7);
    emit(OP_PUT,3); emit(OP_LDM,1); emit(OP_PUT,4); emit(OP_LDI,0);
    emit(OP_PUT,5); emit(OP_PUT,6); emit(OP_BZ,9);
    emit(OP_GET,5); emit(OP_ADD,2); emit(OP_PUT,5); emit(OP_GET,6);
    emit(OP_ADC,3); emit(OP_PUT,6); emit(OP_LDI,0); emit(OP_BZ,4);
    emit(OP_LDI,1); emit(OP_AND,4); emit(OP_BNZ,-10);
    emit(OP_GET,2); emit(OP_ADD,2); emit(OP_PUT,2); emit(OP_GET,3);
    emit(OP_ADC,3); emit(OP_PUT,3); emit(OP_GET,4); emit(OP_SHR,0);
    emit(OP_PUT,4); emit(OP_BNZ,-12);
    emit(OP_LDM,1); emit(OP_SHL,0); emit(OP_LDI,0); emit(OP_ADC,0);
    emit(OP_BZ,8);
    emit(OP_LDI,0); emit(OP_PUT,7); emit(OP_LDM,7); emit(OP_PUT,7);
    emit(OP_GET,6); emit(OP_SUB,7); emit(OP_PUT,6);
    emit(OP_LDI,2); emit(OP_PUT,7); emit(OP_GET,5); emit(OP_STM,7);
    emit(OP_LDI,3); emit(OP_PUT,7); emit(OP_GET,6); emit(OP_STM,7);
    emit(OP_HALT,0);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] b);
    u_dut.dm.core[0] = a;
    u_dut.dm.core[1] = b;
    u_dut.dm.core[2] = 8'h5A;
    u_dut.dm.core[3] = 8'h5A;
  endtask

  task automatic do_reset(input logic st);
    start = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = st;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 1000 && done !== 1'b1; k++) @(negedge clk);
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic run_mul(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] p);
    preload(a, b);
    do_reset(1'b0);
    wait_done(tag);
    chk(tag, 32'(u_dut.dm.core[3]), 32'(p[15:8]));
    chk(tag, 32'(u_dut.dm.core[2]), 32'(p[7:0]));
  endtask

  initial begin
    load_mul();
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pc", 32'(u_dut.r_pc), 32'd0);
    chk("rst_r0", 32'(u_dut.r_rf[0]), 32'd0);
    chk("rst_z", 32'(u_dut.r_z), 32'd0);
    chk("rst_c", 32'(u_dut.r_c), 32'd0);
    reset = 1'b1;

    run_mul("m_2x-4", 8'h02, 8'hFC, 16'hFFF8);
    run_mul("m_-128sq", 8'h80, 8'h80, 16'h4000);
    run_mul("m_127x-128", 8'h7F, 8'h80, 16'hC080);
    run_mul("m_0x-1", 8'h00, 8'hFF, 16'h0000);

    preload(8'h05, 8'h07);
    do_reset(1'b1);
    repeat (20) @(negedge clk);
    chk("hold_done", 32'(done), 32'd0);
    chk("hold_pc", 32'(u_dut.r_pc), 32'd0);
    chk("hold_dm2", 32'(u_dut.dm.core[2]), 32'h5A);
    chk("hold_dm3", 32'(u_dut.dm.core[3]), 32'h5A);
    start = 1'b0;
    wait_done("hold_run");
    chk("hold_hi", 32'(u_dut.dm.core[3]), 32'h00);
    chk("hold_lo", 32'(u_dut.dm.core[2]), 32'h23);

    preload(8'hFD, 8'h09);
    do_reset(1'b0);
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_pc", 32'(u_dut.r_pc), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_r0", 32'(u_dut.r_rf[0]), 32'd0);
    chk("mid_dm0", 32'(u_dut.dm.core[0]), 32'hFD);
    chk("mid_dm1", 32'(u_dut.dm.core[1]), 32'h09);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wait_done("mid_run");
    chk("mid_hi", 32'(u_dut.dm.core[3]), 32'hFF);
    chk("mid_lo", 32'(u_dut.dm.core[2]), 32'hE5);

    start = 1'b1;
    @(posedge clk);
    #1;
    chk("re_done", 32'(done), 32'd0);
    chk("re_pc", 32'(u_dut.r_pc), 32'd0);
    @(negedge clk);
    u_dut.dm.core[2] = 8'h00;
    u_dut.dm.core[3] = 8'h00;
    start = 1'b0;
    wait_done("re_run");
    chk("re_hi", 32'(u_dut.dm.core[3]), 32'hFF);
    chk("re_lo", 32'(u_dut.dm.core[2]), 32'hE5);

    clear_im();
    do_reset(1'b1);
    start = 1'b0;
    chk("halt_pre", 32'(done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_pc", 32'(u_dut.r_pc), 32'd0);

    clear_im();
    emit(OP_LDI,3); emit(OP_PUT,2); emit(OP_LDI,5); emit(OP_MUL,2);
    emit(OP_HALT,0);
    do_reset(1'b0);
    wait_done("op12_run");
`ifdef MUL_INSTR_EN
    chk("mul_r1", 32'(u_dut.r_rf[1]), 32'h00);
    chk("mul_r0", 32'(u_dut.r_rf[0]), 32'h0F);
    chk("mul_z", 32'(u_dut.r_z), 32'd0);
`else
    chk("nop_r1", 32'(u_dut.r_rf[1]), 32'h00);
    chk("nop_r0", 32'(u_dut.r_rf[0]), 32'h05);
    chk("nop_pc", 32'(u_dut.r_pc), 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
